// File: rtl/ser2par8.sv
// ser2par8: 8-bit serial-to-parallel receiver with registered Load strobe.
// Define SER2PAR8_PARITY_CHECK_EN to add a 9th (even parity) bit and the Par_Err flag.
module ser2par8 #(
   parameter int LSB_FIRST = 1
) (
   input  logic       clk,
   input  logic       res,
   input  logic       Start,
   input  logic       Ser_In,
   output logic [7:0] Par_Out,
   output logic       Load,
   output logic       Busy,
   output logic       Par_Err
);
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
   state_t state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] sr_q, sr_d, par_out_q, par_out_d;
   logic load_q, load_d, enter_done;
`ifdef SER2PAR8_PARITY_CHECK_EN
   logic par_err_q, par_err_d;
`endif

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q   <= IDLE;
         cnt_q     <= 3'd0;
         sr_q      <= 8'h00;
         par_out_q <= 8'h00;
         load_q    <= 1'b0;
`ifdef SER2PAR8_PARITY_CHECK_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sr_q      <= sr_d;
         par_out_q <= par_out_d;
         load_q    <= load_d;
`ifdef SER2PAR8_PARITY_CHECK_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   state_d = Start ? SHIFT : IDLE;
`ifdef SER2PAR8_PARITY_CHECK_EN
         SHIFT:  state_d = (cnt_q == 3'd7) ? PARITY : SHIFT;
`else
         SHIFT:  state_d = (cnt_q == 3'd7) ? DONE : SHIFT;
`endif
         PARITY: state_d = DONE;
         DONE:   state_d = Start ? SHIFT : IDLE;
      endcase
   end

   // Counter idles at zero, so every entry into SHIFT starts a fresh word.
   always_comb begin
      enter_done = (state_d == DONE) && (state_q != DONE);
      cnt_d      = (state_q == SHIFT) ? cnt_q + 3'd1 : 3'd0;
      sr_d       = (state_q != SHIFT) ? sr_q :
                   (LSB_FIRST != 0)   ? {Ser_In, sr_q[7:1]} : {sr_q[6:0], Ser_In};
      par_out_d  = enter_done ? sr_d : par_out_q;
      load_d     = enter_done;
`ifdef SER2PAR8_PARITY_CHECK_EN
      par_err_d  = enter_done ? ^{sr_q, Ser_In} : par_err_q;
`endif
   end

   always_comb begin
      Busy    = (state_q == SHIFT) || (state_q == PARITY);
      Par_Out = par_out_q;
      Load    = load_q;
`ifdef SER2PAR8_PARITY_CHECK_EN
      Par_Err = par_err_q;
`else
      Par_Err = 1'b0;
`endif
   end
endmodule

// File: tb/tb_ser2par8.sv
// tb_ser2par8: directed + randomized bench for ser2par8, both bit orders side by side.
module tb_ser2par8;
`ifdef SER2PAR8_PARITY_CHECK_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   logic clk = 1'b0, res = 1'b1, Start = 1'b0, Ser_In = 1'b0;
   logic [7:0] po_l, po_m;
   logic ld_l, ld_m, bz_l, bz_m, pe_l, pe_m;
   int tests = 0, fails = 0;
   logic [7:0] last_l = 8'h00, last_m = 8'h00;
   logic last_e = 1'b0;

   ser2par8 #(.LSB_FIRST(1)) dut_l (.clk(clk), .res(res), .Start(Start), .Ser_In(Ser_In),
      .Par_Out(po_l), .Load(ld_l), .Busy(bz_l), .Par_Err(pe_l));
   ser2par8 #(.LSB_FIRST(0)) dut_m (.clk(clk), .res(res), .Start(Start), .Ser_In(Ser_In),
      .Par_Out(po_m), .Load(ld_m), .Busy(bz_m), .Par_Err(pe_m));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_load"}, {6'd0, ld_l, ld_m}, 8'h00);
      chk({tag, "_busy"}, {6'd0, bz_l, bz_m}, 8'h00);
      chk({tag, "_po_l"}, po_l, last_l);
      chk({tag, "_po_m"}, po_m, last_m);
      chk({tag, "_perr"}, {6'd0, pe_l, pe_m}, {6'd0, last_e, last_e});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         Start = 1'b0;
         Ser_In = 1'($urandom);
         tick;
         chk_quiet("idle");
      end
   endtask

   // bits[i] is the i-th bit on the wire; smode: 0 Start low, 1 random Start, 2 Start held high
   task automatic recv(input logic [7:0] bits, input logic p, input int smode);
      logic [7:0] el, em;
      logic ee;
      for (int i = 0; i < 8; i++) begin
         el[i] = bits[i];
         em[7 - i] = bits[i];
      end
      ee = (PAR != 0) ? ((^bits) ^ p) : 1'b0;
      Start = 1'b1;
      Ser_In = 1'($urandom);
      tick;
      chk("start_busy", {6'd0, bz_l, bz_m}, 8'h03);
      chk("start_load", {6'd0, ld_l, ld_m}, 8'h00);
      for (int i = 0; i < 8 + PAR; i++) begin
         Ser_In = (i < 8) ? bits[i] : p;
         Start = (smode == 2) ? 1'b1 : (smode == 1) ? 1'($urandom) : 1'b0;
         tick;
         if (i < 7 + PAR) begin
            chk("shift_busy", {6'd0, bz_l, bz_m}, 8'h03);
            chk("shift_load", {6'd0, ld_l, ld_m}, 8'h00);
            chk("shift_hold_l", po_l, last_l);
            chk("shift_hold_m", po_m, last_m);
         end
      end
      chk("done_load", {6'd0, ld_l, ld_m}, 8'h03);
      chk("done_busy", {6'd0, bz_l, bz_m}, 8'h00);
      chk("word_lsb", po_l, el);
      chk("word_msb", po_m, em);
      chk("perr", {6'd0, pe_l, pe_m}, {6'd0, ee, ee});
      last_l = el;
      last_m = em;
      last_e = ee;
   endtask

   initial begin
      res = 1'b1;
      Start = 1'b1;
      Ser_In = 1'b1;
      repeat (3) tick;
      chk_quiet("reset");
      res = 1'b0;
      recv(8'hA5, 1'b0, 0);
      idle(2);
      recv(8'h03, 1'b0, 0);
      idle(1);
      recv(8'h5A, 1'b0, 2);
      recv(8'h3C, 1'b0, 2);
      idle(2);
      recv(8'h0F, 1'b1, 0);
      idle(1);
      recv(8'h0F, 1'b0, 0);
      recv(8'h96, 1'b1, 1);
      idle(1);
      Start = 1'b1;
      tick;
      Start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         Ser_In = 1'($urandom);
         tick;
      end
      #2 res = 1'b1;
      #1;
      last_l = 8'h00;
      last_m = 8'h00;
      last_e = 1'b0;
      chk_quiet("async_res");
      tick;
      res = 1'b0;
      idle(3);
      recv(8'hC3, 1'b1, 0);
      for (int n = 0; n < 25; n++) begin
         recv(8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
         idle(int'($urandom_range(0, 2)));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
